// File: rtl/hilo_div_sequencer_if.sv
// -----------------------------------------------------------------------------
// hilo_div_if
// Bundles the signals between the instruction decode/ALU side and the
// iterative hi/lo divide sequencer.
//
// Parameter:
//   WIDTH        operand/result width in bits
//
// Signals (master = decode/ALU side, slave = hilo_div_sequencer):
//   start        master->slave  decoded div in current instruction
//   dividend     master->slave  rs operand
//   divisor      master->slave  rt operand
//   hilo_rd_req  master->slave  decoded mfhi/mflo in current instruction
//   is_signed    master->slave  signed divide (only with SIGNED_DIV_EN)
//   busy         slave->master  sequencer not idle
//   stall        slave->master  freeze PC / register write this cycle
//   hilo_we      slave->master  one-cycle hi/lo write strobe
//   lo_wd        slave->master  quotient
//   hi_wd        slave->master  remainder
//   done         slave->master  one-cycle completion pulse
//   div_by_zero  slave->master  qualifies done: divisor was zero
//
// Optional feature macro: SIGNED_DIV_EN adds the is_signed signal.
// -----------------------------------------------------------------------------
interface hilo_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             hilo_rd_req;
`ifdef SIGNED_DIV_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             stall;
  logic             hilo_we;
  logic [WIDTH-1:0] lo_wd;
  logic [WIDTH-1:0] hi_wd;
  logic             done;
  logic             div_by_zero;

`ifdef SIGNED_DIV_EN
  modport master (
    output start, dividend, divisor, hilo_rd_req, is_signed,
    input  busy, stall, hilo_we, lo_wd, hi_wd, done, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor, hilo_rd_req, is_signed,
    output busy, stall, hilo_we, lo_wd, hi_wd, done, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor, hilo_rd_req,
    input  busy, stall, hilo_we, lo_wd, hi_wd, done, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor, hilo_rd_req,
    output busy, stall, hilo_we, lo_wd, hi_wd, done, div_by_zero
  );
`endif
endinterface

// File: rtl/hilo_div_sequencer.sv
// -----------------------------------------------------------------------------
// hilo_div_sequencer
// Multi-cycle radix-2 restoring divider that owns the hi/lo write path.
// A div is captured from IDLE, one quotient bit is produced per CALC cycle,
// and a single DONE cycle strobes hilo_we/done with quotient (lo_wd) and
// remainder (hi_wd). stall holds the pipeline while an mfhi/mflo or a new
// div would collide with an in-flight divide (including the DONE cycle).
//
// Parameters:
//   WIDTH   operand/result width
//   CNT_W   iteration counter width, 2**CNT_W must exceed WIDTH
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high; aborts any divide without a write
//   bus     hilo_div_if slave modport (see interface header)
//
// Optional feature macro: SIGNED_DIV_EN
//   Adds bus.is_signed. Signed divides run on magnitudes; the quotient is
//   negated when operand signs differ and the remainder follows the dividend
//   sign. The fix-up is applied when lo/hi load, so latency is unchanged.
// -----------------------------------------------------------------------------
module hilo_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  hilo_div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dz_q, dz_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  // One restoring step: shift {rem,quo} left and try to subtract the divisor.
  logic [WIDTH:0]         rem_sh;
  logic signed [WIDTH:0]  trial;
  logic                   trial_neg;
  logic [WIDTH-1:0]       rem_nxt;
  logic [WIDTH-1:0]       quo_nxt;

  logic                   divisor_zero;
  logic                   sgn_dividend;
  logic                   sgn_divisor;

  // Two's-complement negate when requested.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? -v : v;
  endfunction

  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign trial     = $signed(rem_sh) - $signed({1'b0, dsr_q});
  assign trial_neg = trial[WIDTH];
  assign rem_nxt   = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], ~trial_neg};

  assign divisor_zero = (bus.divisor == '0);

`ifdef SIGNED_DIV_EN
  assign sgn_dividend = bus.is_signed & bus.dividend[WIDTH-1];
  assign sgn_divisor  = bus.is_signed & bus.divisor[WIDTH-1];
`else
  assign sgn_dividend = 1'b0;
  assign sgn_divisor  = 1'b0;
`endif

  // Next-state and datapath load logic.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (divisor_zero) begin
            // Divide-by-zero result is fixed and needs no iterations.
            lo_d    = '1;
            hi_d    = bus.dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dz_d      = 1'b0;
            rem_d     = '0;
            quo_d     = apply_sign(bus.dividend, sgn_dividend);
            dsr_d     = apply_sign(bus.divisor, sgn_divisor);
            cnt_d     = '0;
            neg_quo_d = sgn_dividend ^ sgn_divisor;
            neg_rem_d = sgn_dividend;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final bit: publish results with sign fix-up in the same cycle.
          lo_d    = apply_sign(quo_nxt, neg_quo_q);
          hi_d    = apply_sign(rem_nxt, neg_rem_q);
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Stall covers the DONE cycle too, so hi/lo reads never see stale data and
  // a start during DONE re-presents into the following IDLE cycle.
  assign bus.busy        = (state_q != IDLE);
  assign bus.stall       = bus.busy & (bus.hilo_rd_req | bus.start);
  assign bus.hilo_we     = (state_q == DONE);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = (state_q == DONE) & dz_q;
  assign bus.lo_wd       = lo_q;
  assign bus.hi_wd       = hi_q;

endmodule

// File: tb/tb_hilo_div_sequencer.sv
module tb_hilo_div_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  hilo_div_if #(.WIDTH(W)) bus ();

  hilo_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  bit run_chk  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!reset && bus.busy) busy_cnt <= busy_cnt + 1;
  always @(negedge clk) if (!reset && bus.hilo_we) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: results from plain arithmetic, timing as a countdown of
  // busy cycles (WIDTH iterations + 1 DONE cycle, or 1 for divide-by-zero).
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic         sgn);
    logic signed [W-1:0] sq, sr;
    if (sgn) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return {sq, sr};
    end
    return {a / b, a % b};
  endfunction

  int           m_left;
  logic [W-1:0] m_lo, m_hi, p_lo, p_hi;
  logic         m_dz;
  logic         m_sgn;

`ifdef SIGNED_DIV_EN
  assign m_sgn = bus.is_signed;
`else
  assign m_sgn = 1'b0;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_lo   <= '0;
      m_hi   <= '0;
      m_dz   <= 1'b0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        if (bus.divisor == '0) begin
          m_left <= 1;
          m_lo   <= '1;
          m_hi   <= bus.dividend;
          m_dz   <= 1'b1;
        end else begin
          m_left <= W + 1;
          m_dz   <= 1'b0;
          {p_lo, p_hi} <= ref_div(bus.dividend, bus.divisor, m_sgn);
        end
      end
    end else begin
      if (m_left == 2) begin
        m_lo <= p_lo;
        m_hi <= p_hi;
      end
      m_left <= m_left - 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_chk && !reset) begin
      chk("busy",        bus.busy,        64'(m_left != 0));
      chk("stall",       bus.stall,       64'((m_left != 0) && (bus.hilo_rd_req || bus.start)));
      chk("done",        bus.done,        64'(m_left == 1));
      chk("hilo_we",     bus.hilo_we,     64'(m_left == 1));
      chk("div_by_zero", bus.div_by_zero, 64'((m_left == 1) && m_dz));
      chk("lo_wd",       bus.lo_wd,       64'(m_lo));
      chk("hi_wd",       bus.hi_wd,       64'(m_hi));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sgn, output int s);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef SIGNED_DIV_EN
    bus.is_signed = sgn;
`endif
    @(posedge clk); #1;
    s = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int dc);
    bit ok = 1'b0;
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dc = cyc;
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, dc, dc2, b0, d0;
    bus.start       = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    bus.hilo_rd_req = 1'b0;
`ifdef SIGNED_DIV_EN
    bus.is_signed   = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    bus.busy,        64'd0);
    chk("rst_stall",   bus.stall,       64'd0);
    chk("rst_done",    bus.done,        64'd0);
    chk("rst_hilo_we", bus.hilo_we,     64'd0);
    chk("rst_dz",      bus.div_by_zero, 64'd0);
    chk("rst_lo",      bus.lo_wd,       64'd0);
    chk("rst_hi",      bus.hi_wd,       64'd0);
    reset   = 1'b0;
    run_chk = 1'b1;

    // Basic 100 / 7
    b0 = busy_cnt;
    issue(32'd100, 32'd7, 1'b0, s);
    wait_done("basic", dc);
    chk("basic_lo",      bus.lo_wd,       64'd14);
    chk("basic_hi",      bus.hi_wd,       64'd2);
    chk("basic_dz",      bus.div_by_zero, 64'd0);
    chk("basic_latency", 64'(dc - s),     64'd32);
    @(posedge clk); #1;
    chk("basic_busy_cycles", 64'(busy_cnt - b0), 64'd33);

    // Divide by zero
    issue(32'h0000_1234, 32'd0, 1'b0, s);
    wait_done("dz", dc);
    chk("dz_latency", 64'(dc - s),     64'd0);
    chk("dz_lo",      bus.lo_wd,       64'hFFFF_FFFF);
    chk("dz_hi",      bus.hi_wd,       64'h0000_1234);
    chk("dz_flag",    bus.div_by_zero, 64'd1);

    // Read interlock on 0xFFFFFFFF / 1
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, s);
    repeat (3) @(posedge clk);
    #1 bus.hilo_rd_req = 1'b1;
    wait_done("rd", dc);
    chk("rd_stall_done", bus.stall, 64'd1);
    @(negedge clk);
    chk("rd_idle_busy",  bus.busy,  64'd0);
    chk("rd_idle_stall", bus.stall, 64'd0);
    chk("rd_idle_lo",    bus.lo_wd, 64'hFFFF_FFFF);
    chk("rd_idle_hi",    bus.hi_wd, 64'd0);
    @(posedge clk); #1 bus.hilo_rd_req = 1'b0;

    // Reset abort mid-divide, then a fresh 9 / 3
    d0 = done_cnt;
    issue(32'd1000, 32'd3, 1'b0, s);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy,    64'd0);
    chk("abort_we",   bus.hilo_we, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_we", 64'(done_cnt - d0), 64'd0);
    issue(32'd9, 32'd3, 1'b0, s);
    wait_done("post_abort", dc);
    chk("post_abort_lo", bus.lo_wd, 64'd3);
    chk("post_abort_hi", bus.hi_wd, 64'd0);

    // Back-to-back with start held: 20 / 6 then 50 / 5
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 32'd20;
    bus.divisor  = 32'd6;
    @(posedge clk); #1;
    s = cyc;
    repeat (5) @(negedge clk);
    chk("b2b_stall_busy", bus.stall, 64'd1);
    wait_done("b2b_first", dc);
    chk("b2b_first_lo",    bus.lo_wd, 64'd3);
    chk("b2b_first_hi",    bus.hi_wd, 64'd2);
    chk("b2b_stall_done",  bus.stall, 64'd1);
    @(posedge clk); #1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    wait_done("b2b_second", dc2);
    chk("b2b_second_latency", 64'(dc2 - s), 64'd66);
    chk("b2b_second_lo",      bus.lo_wd,    64'd10);
    chk("b2b_second_hi",      bus.hi_wd,    64'd0);
    @(posedge clk); #1 bus.start = 1'b0;

`ifdef SIGNED_DIV_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, s);
    wait_done("signed", dc);
    chk("signed_lo",      bus.lo_wd,  64'hFFFF_FFFD);
    chk("signed_hi",      bus.hi_wd,  64'hFFFF_FFFF);
    chk("signed_latency", 64'(dc - s), 64'd32);
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, s);
    wait_done("unsigned", dc);
    chk("unsigned_lo", bus.lo_wd, 64'h7FFF_FFFC);
    chk("unsigned_hi", bus.hi_wd, 64'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
